// File: rtl/geofence_host.sv
// -----------------------------------------------------------------------------
// geofence_host
//
// Batch sequencer for a point-in-polygon (geofence) core. Each test reads seven
// 20-bit points (object point, then six fence vertices) from point memory and
// streams them to the core after a one-cycle core reset. It then waits for the
// core's result, or for a timeout, and writes {timeout, inside} to the result
// memory. A running count of inside results is kept for the batch.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin a batch (sampled only in IDLE)
//   num_tests    tests in the batch, latched on an accepted start
//   mem_addr     point-memory read address (point p of test t at 7*t+p)
//   mem_rdata    point word {X,Y}, valid the cycle after mem_addr
//   core_rst     one-cycle reset pulse to the core, issued before every test
//   X, Y         registered coordinate stream to the core
//   valid        core result valid (only honoured while waiting)
//   is_inside    core result
//   res_we       one-cycle result write strobe
//   res_addr     test index of the result write
//   res_data     {timeout, inside}
//   inside_cnt   running count of inside results in the current batch
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the batch completes
// -----------------------------------------------------------------------------
module geofence_host #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_tests,
    output logic [10:0] mem_addr,
    input  logic [19:0] mem_rdata,
    output logic        core_rst,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    input  logic        valid,
    input  logic        is_inside,
    output logic        res_we,
    output logic [7:0]  res_addr,
    output logic [1:0]  res_data,
    output logic [7:0]  inside_cnt,
    output logic        busy,
    output logic        done
);

    // Wait counter just wide enough to reach TMO_CYCLES.
    localparam int CW = (TMO_CYCLES < 1) ? 1 : $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RST,
        S_SEND,
        S_WAIT,
        S_WRITE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      t_q, t_d;             // current test index
    logic [7:0]      num_q, num_d;         // latched batch size
    logic [2:0]      p_q, p_d;             // point index within SEND
    logic [CW-1:0]   wcnt_q, wcnt_d;       // WAIT-state cycle counter
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [1:0]      res_data_q, res_data_d;
    logic [7:0]      inside_cnt_q, inside_cnt_d;
    logic            done_q, done_d;

    logic [10:0]     addr_base;
    logic [10:0]     addr_off;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            num_q        <= '0;
            p_q          <= '0;
            wcnt_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            res_data_q   <= '0;
            inside_cnt_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            num_q        <= num_d;
            p_q          <= p_d;
            wcnt_q       <= wcnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            res_data_q   <= res_data_d;
            inside_cnt_q <= inside_cnt_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        num_d        = num_q;
        p_d          = p_q;
        wcnt_d       = wcnt_q;
        x_d          = x_q;
        y_d          = y_q;
        res_data_d   = res_data_q;
        inside_cnt_d = inside_cnt_q;
        done_d       = 1'b0;

        // The coordinate pipeline follows the memory read stream while
        // fetching/sending; the word loaded at the end of RST is point 0.
        if (state_q == S_PRE || state_q == S_RST || state_q == S_SEND) begin
            x_d = mem_rdata[19:10];
            y_d = mem_rdata[9:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d        = num_tests;
                    t_d          = '0;
                    inside_cnt_d = '0;
                    // An empty batch completes immediately without touching
                    // the core.
                    if (num_tests == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end

            S_PRE: begin
                state_d = S_RST;
            end

            S_RST: begin
                p_d     = '0;
                state_d = S_SEND;
            end

            S_SEND: begin
                if (p_q == 3'd6) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    p_d = p_q + 3'd1;
                end
            end

            S_WAIT: begin
                // A result arriving on the timeout cycle still counts as a
                // normal result.
                if (valid) begin
                    res_data_d = {1'b0, is_inside};
                    state_d    = S_WRITE;
                end else if (wcnt_q == CW'(TMO_CYCLES)) begin
                    res_data_d = 2'b10;
                    state_d    = S_WRITE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end

            S_WRITE: begin
                inside_cnt_d = inside_cnt_q + {7'd0, res_data_q[0]};
                // Compare at 9 bits so the last test of a 255-test batch
                // cannot wrap.
                if (({1'b0, t_q} + 9'd1) == {1'b0, num_q}) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    t_d     = t_q + 8'd1;
                    state_d = S_PRE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Point-memory address: 7*t computed as 8*t - t at 11 bits (max 1785),
    // plus the per-state point offset.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_base = ({3'b000, t_q} << 3) - {3'b000, t_q};
        unique case (state_q)
            S_RST:   addr_off = 11'd1;
            S_SEND:  addr_off = {8'd0, p_q} + 11'd2;
            default: addr_off = 11'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_addr   = addr_base + addr_off;
    assign core_rst   = (state_q == S_RST);
    assign res_we     = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign res_addr   = t_q;
    assign res_data   = res_data_q;
    assign inside_cnt = inside_cnt_q;
    assign done       = done_q;
    assign X          = x_q;
    assign Y          = y_q;

endmodule

// File: tb/tb_geofence_host.sv
// -----------------------------------------------------------------------------
// tb_geofence_host
//
// Directed bench for geofence_host. A point-memory model and a scripted core
// model surround the DUT. Stimulus pushes the expected result writes
// {res_addr, res_data, cycle-after-core_rst} into a scoreboard queue; a monitor
// pops and compares them whenever res_we is seen.
// -----------------------------------------------------------------------------
module tb_geofence_host;

    localparam int TMO = 20;
    localparam int NG  = 11;   // number of scripted core_rst events

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_tests;
    logic [10:0] mem_addr;
    logic [19:0] mem_rdata;
    logic        core_rst;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic        valid;
    logic        is_inside;
    logic        res_we;
    logic [7:0]  res_addr;
    logic [1:0]  res_data;
    logic [7:0]  inside_cnt;
    logic        busy;
    logic        done;

    geofence_host #(.TMO_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_tests  (num_tests),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .core_rst   (core_rst),
        .X          (X),
        .Y          (Y),
        .valid      (valid),
        .is_inside  (is_inside),
        .res_we     (res_we),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .inside_cnt (inside_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Point memory: one-cycle read latency
    // -------------------------------------------------------------------------
    logic [19:0] mem [0:2047];

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // -------------------------------------------------------------------------
    // Core script, one entry per core_rst pulse in run order.
    //   tidx   : test index the DUT should be on
    //   resp_c : WAIT-counter value at which valid is raised (-1 = never)
    //   resp_in: is_inside value returned
    //   spur   : also raise a stray valid during SEND point 2
    // -------------------------------------------------------------------------
    int tidx    [NG] = '{0,  0, 1, 2,  0, 1,   2,     0, 1,   0, 1};
    int resp_c  [NG] = '{5,  2, 0, 7, -1, TMO, TMO-1, 1, -1,  3, 4};
    int resp_in [NG] = '{1,  1, 0, 1,  0, 1,   0,     1, 0,   1, 1};
    int spur    [NG] = '{0,  0, 1, 0,  0, 0,   0,     0, 0,   0, 0};

    int g     = -1;   // index of the current core_rst event
    int k     = 0;    // cycles since the last core_rst (0 = RST cycle)
    int n_rst = 0;

    initial begin
        valid     = 1'b0;
        is_inside = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (core_rst === 1'b1) begin
                g++;
                k = 0;
                n_rst++;
            end else begin
                k++;
            end
            valid     = 1'b0;
            is_inside = 1'b0;
            if (g >= 0 && g < NG) begin
                // SEND point p is visible at k = p+1
                if (k >= 1 && k <= 7) begin
                    logic [19:0] w;
                    w = mem[7 * tidx[g] + k - 1];
                    check($sformatf("X_g%0d_p%0d", g, k - 1), X, w[19:10]);
                    check($sformatf("Y_g%0d_p%0d", g, k - 1), Y, w[9:0]);
                end
                if (resp_c[g] >= 0 && k == 8 + resp_c[g]) begin
                    valid     = 1'b1;
                    is_inside = resp_in[g][0];
                end
                if (spur[g] != 0 && k == 3) begin
                    valid     = 1'b1;
                    is_inside = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and monitor
    // -------------------------------------------------------------------------
    typedef struct {
        int addr;
        int data;
        int kk;     // expected k of the WRITE cycle
    } wr_exp_s;

    wr_exp_s q[$];
    int      n_done = 0;

    task automatic push(input int addr, input int data, input int kk);
        wr_exp_s e;
        e.addr = addr;
        e.data = data;
        e.kk   = kk;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (res_we === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: res_addr=%0d res_data=%0d, no write expected",
                             res_addr, res_data);
                end else begin
                    wr_exp_s e;
                    e = q.pop_front();
                    check("res_addr", res_addr, e.addr);
                    check("res_data", res_data, e.data);
                    check("write_cycle", k, e.kk);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic issue_start(input logic [7:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_tests = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_tests = 8'd0;
    endtask

    task automatic wait_done(input int d0, input int limit, input string name);
        int i = 0;
        while (n_done == d0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({name, "_done"}, n_done - d0, 1);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int r0;

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        // Test 0: object (5,5) in the 10x10 hexagon-ish fence
        mem[0] = {10'd5,  10'd5};
        mem[1] = {10'd0,  10'd0};
        mem[2] = {10'd10, 10'd0};
        mem[3] = {10'd10, 10'd10};
        mem[4] = {10'd0,  10'd10};
        mem[5] = {10'd0,  10'd5};
        mem[6] = {10'd10, 10'd5};
        for (int t = 1; t < 3; t++) begin
            for (int p = 0; p < 7; p++) begin
                mem[7 * t + p] = {10'(100 * t + p), 10'(50 * t + 2 * p)};
            end
        end

        // ---- Reset, with start held high to show reset priority ----
        reset     = 1'b1;
        start     = 1'b1;
        num_tests = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_core_rst",   core_rst,   0);
        check("rst_res_we",     res_we,     0);
        check("rst_X",          X,          0);
        check("rst_Y",          Y,          0);
        check("rst_mem_addr",   mem_addr,   0);
        check("rst_res_addr",   res_addr,   0);
        check("rst_res_data",   res_data,   0);
        check("rst_inside_cnt", inside_cnt, 0);
        start     = 1'b0;
        num_tests = 8'd0;
        reset     = 1'b0;

        // ---- Batch A: one test, inside after 5 WAIT cycles ----
        d0 = n_done;
        r0 = n_rst;
        push(0, 2'b01, 14);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_tests = 8'd1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        @(negedge clk);                       // cycle 0: PRE
        check("A_busy_pre",      busy,     1);
        check("A_core_rst_c0",   core_rst, 0);
        check("A_mem_addr_pre",  mem_addr, 0);
        @(negedge clk);                       // cycle 1: RST
        check("A_core_rst_c1",   core_rst, 1);
        check("A_mem_addr_rst",  mem_addr, 1);
        @(negedge clk);                       // cycle 2: SEND p=0
        check("A_X_c2",          X,        5);
        check("A_Y_c2",          Y,        5);
        check("A_core_rst_c2",   core_rst, 0);
        check("A_mem_addr_send", mem_addr, 2);
        wait_done(d0, 100, "A");
        check("A_inside_cnt", inside_cnt, 1);
        check("A_rst_pulses", n_rst - r0, 1);
        check("A_queue",      q.size(),   0);
        @(negedge clk);
        check("A_done_width", done,       0);
        check("A_busy_idle",  busy,       0);

        // ---- Batch B: in/out/in, stray valid in SEND, start pulse in SEND ----
        d0 = n_done;
        r0 = n_rst;
        push(0, 2'b01, 11);
        push(1, 2'b00, 9);
        push(2, 2'b01, 16);
        issue_start(8'd3);                    // now in PRE
        @(posedge clk);
        #1;                                   // RST
        @(posedge clk);
        #1;                                   // SEND p=0
        start     = 1'b1;
        num_tests = 8'd1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_tests = 8'd0;
        wait_done(d0, 300, "B");
        check("B_inside_cnt", inside_cnt, 2);
        repeat (20) @(negedge clk);
        check("B_rst_pulses", n_rst - r0,  3);
        check("B_one_done",   n_done - d0, 1);
        check("B_queue",      q.size(),    0);
        check("B_busy_idle",  busy,        0);

        // ---- Batch C: timeout, valid on timeout cycle, valid just before ----
        d0 = n_done;
        r0 = n_rst;
        push(0, 2'b10, 29);
        push(1, 2'b01, 29);
        push(2, 2'b00, 28);
        issue_start(8'd3);
        wait_done(d0, 400, "C");
        check("C_inside_cnt", inside_cnt, 1);
        check("C_rst_pulses", n_rst - r0, 3);
        check("C_queue",      q.size(),   0);

        // ---- Batch D: reset in WAIT of test 1 of 3 ----
        d0 = n_done;
        r0 = n_rst;
        push(0, 2'b01, 10);
        issue_start(8'd3);
        begin
            int i = 0;
            while (!(g == 8 && k == 10) && i < 200) begin
                @(negedge clk);
                i++;
            end
            check("D_reached_wait", (g == 8 && k == 10) ? 1 : 0, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("D_busy",       busy,       0);
        check("D_res_we",     res_we,     0);
        check("D_done",       done,       0);
        check("D_core_rst",   core_rst,   0);
        check("D_X",          X,          0);
        check("D_res_data",   res_data,   0);
        check("D_inside_cnt", inside_cnt, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("D_no_done",    n_done - d0, 0);
        check("D_rst_pulses", n_rst - r0,  2);
        check("D_queue",      q.size(),    0);
        check("D_busy_after", busy,        0);

        // ---- Batch E: fresh batch after abort restarts at test 0 ----
        d0 = n_done;
        r0 = n_rst;
        push(0, 2'b01, 12);
        push(1, 2'b01, 13);
        issue_start(8'd2);
        wait_done(d0, 300, "E");
        check("E_inside_cnt", inside_cnt, 2);
        check("E_rst_pulses", n_rst - r0, 2);
        check("E_queue",      q.size(),   0);

        // ---- Batch F: empty batch ----
        d0 = n_done;
        r0 = n_rst;
        issue_start(8'd0);                    // one cycle after the accepting edge
        @(negedge clk);
        check("F_done",       done,        1);
        check("F_busy",       busy,        0);
        @(negedge clk);
        check("F_done_width", done,        0);
        repeat (10) @(negedge clk);
        check("F_no_rst",     n_rst - r0,  0);
        check("F_one_done",   n_done - d0, 1);
        check("F_queue",      q.size(),    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/geofence_host.md
GEOFENCE_HOST -- requirements
Module: geofence_host

Interface
REQ-001 Parameter TMO_CYCLES, default 255: maximum WAIT-state cycles allowed before a test is declared timed out.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a batch; sampled only in IDLE.
REQ-005 num_tests  input  8  number of tests in the batch; latched on accepted start.
REQ-006 mem_addr  output  11  point-memory read address; point p of test t is at 7*t+p.
REQ-007 mem_rdata  input  20  point word, {X[9:0],Y[9:0]}, valid the cycle after mem_addr.
REQ-008 core_rst  output  1  one-cycle reset pulse to the geofence core.
REQ-009 X, Y  output  10 each  registered coordinate stream to the core.
REQ-010 valid, is_inside  input  1 each  core result handshake.
REQ-011 res_we  output  1  one-cycle result write strobe.
REQ-012 res_addr  output  8  test index for the result write.
REQ-013 res_data  output  2  {timeout, inside}.
REQ-014 inside_cnt  output  8  running count of inside results in the current batch.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the batch completes.

Function
REQ-017 States SHALL be IDLE, PRE, RST, SEND, WAIT, WRITE; busy = (state != IDLE).
REQ-018 IDLE->PRE on start; num_tests latched, test index t=0, inside_cnt cleared; if num_tests==0, the FSM SHALL stay in IDLE and pulse done the next cycle.
REQ-019 PRE (1 cycle): mem_addr=7t+0.
REQ-020 RST (1 cycle): core_rst=1, mem_addr=7t+1.
REQ-021 SEND (7 cycles, p=0..6): X/Y hold point p of test t in SEND cycle p (object point first, then 6 fence vertices); mem_addr=7t+p+2 while p<5, don't-care otherwise.
REQ-022 X/Y SHALL be loaded from mem_rdata each PRE/RST/SEND edge and hold their last value in all other states.
REQ-023 After SEND p=6 -> WAIT; the wait counter clears on WAIT entry and increments each WAIT cycle.
REQ-024 WAIT: valid=1 -> WRITE with res_data={0,is_inside}; counter==TMO_CYCLES without valid -> WRITE with res_data={1,0}.
REQ-025 valid arriving in the same cycle the counter reaches TMO_CYCLES SHALL be treated as a normal result (valid wins).
REQ-026 WRITE (1 cycle): res_we=1, res_addr=t, inside_cnt += res_data[0] (8-bit wrap); then t+1==num_tests -> IDLE with done pulse, else t++ -> PRE.
REQ-027 valid is ignored outside WAIT; start is ignored while busy.
REQ-028 core_rst SHALL be issued before every test, so the core's post-result sampling never affects the next test.
REQ-029 Latency: WRITE occurs exactly 1 cycle after the WAIT cycle in which valid is seen; per-test overhead is PRE+RST+SEND = 9 cycles plus core compute time.
REQ-030 mem_addr SHALL be computed at 11 bits without overflow for t<=255.

Reset
REQ-031 reset SHALL force IDLE; core_rst, res_we, done, busy = 0; X, Y, mem_addr, res_addr, res_data, inside_cnt, t, counters = 0.
REQ-032 reset mid-batch SHALL abort the batch without res_we or done pulses; start is sampled again from the cycle after reset deasserts.
REQ-033 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 num_tests=1, memory 0..6 = (5,5),(0,0),(10,0),(10,10),(0,10),(0,5),(10,5), core model valid=1/is_inside=1 five cycles after SEND -> core_rst at cycle 1 after start, X=5,Y=5 at cycle 2, res_we with res_addr=0, res_data=01, inside_cnt=1, done pulse.
REQ-035 num_tests=3 with results in/out/in -> three writes at res_addr 0,1,2, res_data 01,00,01, inside_cnt=2, exactly 3 core_rst pulses, one done.
REQ-036 Core model never asserts valid -> WRITE after TMO_CYCLES WAIT cycles with res_data=10, inside_cnt unchanged, batch continues to the next test.
REQ-037 valid coincident with the timeout cycle -> res_data={0,is_inside}.
REQ-038 reset asserted in WAIT of test 1 of 3 -> no further res_we/done, busy=0; new start runs from test 0.
REQ-039 start with num_tests=0 -> done one cycle later, no core_rst, no res_we; start pulse during SEND -> no effect.
